// File: rtl/fpmul_arbiter.sv
// fpmul_arbiter: round-robin arbiter/sequencer sharing one binary32 multiplier among NREQ
// requesters. One operand pair is accepted at a time. The pair is held in registers on
// mul_a/mul_b while the multiplier settles for MUL_LAT cycles. The product is then captured
// and returned with the owning requester's ID.
//
// Optional feature: define FPMUL_ARB_FLAGS_EN to add resp_flags = {nan, inf, zero}. These
// flags are classified from the captured product.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready   per-requester request handshake; req_ready is one-hot or zero
//   req_a/req_b           packed operands, requester i at [32i+31:32i]
//   mul_a/mul_b/mul_r     registered operands to, and product from, the shared multiplier
//   resp_valid/ready      response handshake
//   resp_id/resp_data     owning requester and captured product
//   resp_flags            (FPMUL_ARB_FLAGS_EN only) {nan, inf, zero} of resp_data
//   busy                  high whenever not idle
module fpmul_arbiter #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned MUL_LAT = 1,
  parameter int unsigned IDW     = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [32*NREQ-1:0]   req_a,
  input  logic [32*NREQ-1:0]   req_b,
  output logic [31:0]          mul_a,
  output logic [31:0]          mul_b,
  input  logic [31:0]          mul_r,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [IDW-1:0]       resp_id,
  output logic [31:0]          resp_data,
`ifdef FPMUL_ARB_FLAGS_EN
  output logic [2:0]           resp_flags,
`endif
  output logic                 busy
);

  localparam int unsigned CntW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
  localparam logic [CntW-1:0] CntInit = CntW'(MUL_LAT - 1);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e          state_q;
  logic [IDW-1:0]  ptr_q;
  logic [CntW-1:0] cnt_q;
  logic [IDW-1:0]  id_q;
  logic [31:0]     mul_a_q, mul_b_q;
  logic            resp_valid_q;
  logic [IDW-1:0]  resp_id_q;
  logic [31:0]     resp_data_q;

  logic            grant_found;
  logic [IDW-1:0]  grant_idx;

`ifdef FPMUL_ARB_FLAGS_EN
  logic [2:0]      flags_q;

  function automatic logic [2:0] classify(input logic [31:0] v);
    logic exp_ones, exp_zero, mant_zero;
    exp_ones  = (v[30:23] == 8'hFF);
    exp_zero  = (v[30:23] == 8'h00);
    mant_zero = (v[22:0] == 23'h0);
    return {exp_ones & ~mant_zero, exp_ones & mant_zero, exp_zero & mant_zero};
  endfunction
`endif

  // Round-robin pick: first pending index at or above ptr_q, else the lowest pending index
  // (the wrap-around part of the search).
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!grant_found && req_valid[i] && (i >= int'(ptr_q))) begin
        grant_found = 1'b1;
        grant_idx   = IDW'(i);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!grant_found && req_valid[i]) begin
        grant_found = 1'b1;
        grant_idx   = IDW'(i);
      end
    end
  end

  // Gated by rst_n so that no grant is shown while reset is held.
  always_comb begin
    req_ready = '0;
    if (rst_n && (state_q == StIdle) && grant_found) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      ptr_q        <= '0;
      cnt_q        <= '0;
      id_q         <= '0;
      mul_a_q      <= '0;
      mul_b_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= '0;
      resp_data_q  <= '0;
`ifdef FPMUL_ARB_FLAGS_EN
      flags_q      <= '0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (grant_found) begin
            mul_a_q <= req_a[32*grant_idx +: 32];
            mul_b_q <= req_b[32*grant_idx +: 32];
            id_q    <= grant_idx;
            ptr_q   <= (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
            cnt_q   <= CntInit;
            state_q <= StExec;
          end
        end
        StExec: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            resp_data_q  <= mul_r;
            resp_id_q    <= id_q;
            resp_valid_q <= 1'b1;
`ifdef FPMUL_ARB_FLAGS_EN
            flags_q      <= classify(mul_r);
`endif
            state_q      <= StResp;
          end
        end
        StResp: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            state_q      <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign mul_a      = mul_a_q;
  assign mul_b      = mul_b_q;
  assign resp_valid = resp_valid_q;
  assign resp_id    = resp_id_q;
  assign resp_data  = resp_data_q;
  assign busy       = (state_q != StIdle);
`ifdef FPMUL_ARB_FLAGS_EN
  assign resp_flags = flags_q;
`endif

endmodule

// File: tb/tb_fpmul_arbiter.sv
// Directed bench for fpmul_arbiter. Two instances share clock and reset:
//   d1 with MUL_LAT=1, whose multiplier is purely combinational;
//   d3 with MUL_LAT=3, whose multiplier is combinational plus two register stages.
// Expected results are hand-computed binary32 constants.
module tb_fpmul_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [3:0]   d1_req_valid = '0, d1_req_ready;
  logic [127:0] d1_req_a = '0, d1_req_b = '0;
  logic [31:0]  d1_mul_a, d1_mul_b, d1_mul_r, d1_resp_data;
  logic         d1_resp_valid, d1_resp_ready = 1'b0, d1_busy;
  logic [1:0]   d1_resp_id;

  logic [3:0]   d3_req_valid = '0, d3_req_ready;
  logic [127:0] d3_req_a = '0, d3_req_b = '0;
  logic [31:0]  d3_mul_a, d3_mul_b, d3_mul_r, d3_resp_data;
  logic         d3_resp_valid, d3_resp_ready = 1'b0, d3_busy;
  logic [1:0]   d3_resp_id;
  logic [31:0]  d3_p0, d3_p1;

`ifdef FPMUL_ARB_FLAGS_EN
  logic [2:0]   d1_resp_flags, d3_resp_flags;
`endif

  // Behavioural binary32 multiply (round to nearest even, subnormals flushed).
  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic        s;
    logic [7:0]  ea, eb;
    logic [22:0] ma, mb;
    logic [47:0] p;
    logic [24:0] m;
    logic        g, st;
    int          e;
    s = a[31] ^ b[31];
    ea = a[30:23]; eb = b[30:23]; ma = a[22:0]; mb = b[22:0];
    if ((ea == 8'hFF && ma != '0) || (eb == 8'hFF && mb != '0)) return 32'h7FC00000;
    if (ea == 8'hFF || eb == 8'hFF) begin
      if ((ea == '0 && ma == '0) || (eb == '0 && mb == '0)) return 32'h7FC00000;
      return {s, 8'hFF, 23'h0};
    end
    if (ea == '0 || eb == '0) return {s, 31'h0};
    p = {24'h0, 1'b1, ma} * {24'h0, 1'b1, mb};
    e = int'(ea) + int'(eb) - 127;
    if (p[47]) begin
      m = {1'b0, p[47:24]}; g = p[23]; st = |p[22:0]; e = e + 1;
    end else begin
      m = {1'b0, p[46:23]}; g = p[22]; st = |p[21:0];
    end
    if (g && (st || m[0])) m = m + 25'd1;
    if (m[24]) begin
      m = m >> 1; e = e + 1;
    end
    if (e >= 255) return {s, 8'hFF, 23'h0};
    if (e <= 0) return {s, 31'h0};
    return {s, e[7:0], m[22:0]};
  endfunction

  assign d1_mul_r = fmul(d1_mul_a, d1_mul_b);

  always @(posedge clk) begin
    d3_p0 <= fmul(d3_mul_a, d3_mul_b);
    d3_p1 <= d3_p0;
  end
  assign d3_mul_r = d3_p1;

  fpmul_arbiter #(.NREQ(4), .MUL_LAT(1)) u_d1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (d1_req_valid),
    .req_ready  (d1_req_ready),
    .req_a      (d1_req_a),
    .req_b      (d1_req_b),
    .mul_a      (d1_mul_a),
    .mul_b      (d1_mul_b),
    .mul_r      (d1_mul_r),
    .resp_valid (d1_resp_valid),
    .resp_ready (d1_resp_ready),
    .resp_id    (d1_resp_id),
    .resp_data  (d1_resp_data),
`ifdef FPMUL_ARB_FLAGS_EN
    .resp_flags (d1_resp_flags),
`endif
    .busy       (d1_busy)
  );

  fpmul_arbiter #(.NREQ(4), .MUL_LAT(3)) u_d3 (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (d3_req_valid),
    .req_ready  (d3_req_ready),
    .req_a      (d3_req_a),
    .req_b      (d3_req_b),
    .mul_a      (d3_mul_a),
    .mul_b      (d3_mul_b),
    .mul_r      (d3_mul_r),
    .resp_valid (d3_resp_valid),
    .resp_ready (d3_resp_ready),
    .resp_id    (d3_resp_id),
    .resp_data  (d3_resp_data),
`ifdef FPMUL_ARB_FLAGS_EN
    .resp_flags (d3_resp_flags),
`endif
    .busy       (d3_busy)
  );

  // Polls from just after a falling edge; returns with the condition true at negedge+1.
  task automatic wait_ready(input bit use_d3, input int limit, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < limit; n++) begin
      #1;
      if ((use_d3 ? d3_req_ready : d1_req_ready) != 4'b0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_resp(input bit use_d3, input int limit, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < limit; n++) begin
      #1;
      if (use_d3 ? d3_resp_valid : d1_resp_valid) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    d1_req_valid = 4'hF;
    d3_req_valid = 4'hF;
    repeat (2) @(negedge clk);
    #1;
    total++;
    if ({d1_req_ready, d3_req_ready} !== 8'h00) begin
      bad++; $display("FAIL reset_req_ready got=%h want=00", {d1_req_ready, d3_req_ready});
    end
    total++;
    if ({d1_mul_a, d1_mul_b} !== 64'h0) begin
      bad++; $display("FAIL reset_mul_ops got=%h want=0", {d1_mul_a, d1_mul_b});
    end
    total++;
    if ({d1_resp_valid, d1_resp_id, d1_resp_data} !== 35'h0) begin
      bad++;
      $display("FAIL reset_resp got=%b/%0d/%h want=0/0/0", d1_resp_valid, d1_resp_id,
               d1_resp_data);
    end
    total++;
    if ({d1_busy, d3_busy} !== 2'b00) begin
      bad++; $display("FAIL reset_busy got=%b want=00", {d1_busy, d3_busy});
    end
`ifdef FPMUL_ARB_FLAGS_EN
    total++;
    if ({d1_resp_flags, d3_resp_flags} !== 6'b0) begin
      bad++; $display("FAIL reset_flags got=%b want=0", {d1_resp_flags, d3_resp_flags});
    end
`endif
    d1_req_valid = '0;
    d3_req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_round_robin();
    logic [31:0] rr_exp [4];
    bit ok;
    rr_exp[0] = 32'h40000000;   // 1.0 * 2.0
    rr_exp[1] = 32'h40100000;   // 1.5 * 1.5
    rr_exp[2] = 32'hC1000000;   // -2.0 * 4.0
    rr_exp[3] = 32'h3E800000;   // 0.5 * 0.5
    d1_req_a = {32'h3F000000, 32'hC0000000, 32'h3FC00000, 32'h3F800000};
    d1_req_b = {32'h3F000000, 32'h40800000, 32'h3FC00000, 32'h40000000};
    d1_resp_ready = 1'b1;
    d1_req_valid = 4'hF;
    for (int g = 0; g < 4; g++) begin
      wait_ready(1'b0, 20, ok);
      total++;
      if (!ok || d1_req_ready !== 4'(1 << g)) begin
        bad++; $display("FAIL rr_grant%0d got=%b want=%b", g, d1_req_ready, 4'(1 << g));
      end
      @(negedge clk);
      d1_req_valid[g] = 1'b0;
      wait_resp(1'b0, 20, ok);
      total++;
      if (!ok || d1_resp_id !== 2'(g)) begin
        bad++; $display("FAIL rr_id%0d got=%0d want=%0d", g, d1_resp_id, g);
      end
      total++;
      if (d1_resp_data !== rr_exp[g]) begin
        bad++; $display("FAIL rr_data%0d got=%h want=%h", g, d1_resp_data, rr_exp[g]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_single();
    bit ok;
    d1_req_a[64 +: 32] = 32'hC1900000;
    d1_req_b[64 +: 32] = 32'h41180000;
    d1_resp_ready = 1'b1;
    d1_req_valid = 4'b0100;
    wait_ready(1'b0, 20, ok);
    total++;
    if (!ok || d1_req_ready !== 4'b0100) begin
      bad++; $display("FAIL single_grant got=%b want=0100", d1_req_ready);
    end
    @(negedge clk);
    d1_req_valid = '0;
    #1;
    total++;
    if ({d1_resp_valid, d1_busy, d1_mul_a, d1_mul_b} !== {2'b01, 32'hC1900000, 32'h41180000})
    begin
      bad++;
      $display("FAIL single_exec got=%b/%b/%h/%h want=0/1/c1900000/41180000", d1_resp_valid,
               d1_busy, d1_mul_a, d1_mul_b);
    end
    @(negedge clk);
    #1;
    total++;
    if ({d1_resp_valid, d1_resp_id, d1_resp_data} !== {1'b1, 2'd2, 32'hC32B0000}) begin
      bad++;
      $display("FAIL single_resp got=%b/%0d/%h want=1/2/c32b0000", d1_resp_valid, d1_resp_id,
               d1_resp_data);
    end
    @(negedge clk);
    #1;
    total++;
    if ({d1_resp_valid, d1_busy} !== 2'b00) begin
      bad++; $display("FAIL single_done got=%b%b want=00", d1_resp_valid, d1_busy);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    @(negedge clk);
    d1_req_a[32 +: 32] = 32'h40400000;
    d1_req_b[32 +: 32] = 32'h3F000000;
    d1_req_a[96 +: 32] = 32'h3F000000;
    d1_req_b[96 +: 32] = 32'h3F000000;
    d1_resp_ready = 1'b0;
    d1_req_valid = 4'b0010;
    wait_ready(1'b0, 20, ok);
    total++;
    if (!ok || d1_req_ready !== 4'b0010) begin
      bad++; $display("FAIL bp_grant got=%b want=0010", d1_req_ready);
    end
    @(negedge clk);
    d1_req_valid = 4'b1000;
    wait_resp(1'b0, 20, ok);
    total++;
    if (!ok || {d1_resp_id, d1_resp_data} !== {2'd1, 32'h3FC00000}) begin
      bad++; $display("FAIL bp_resp got=%0d/%h want=1/3fc00000", d1_resp_id, d1_resp_data);
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #1;
      total++;
      if ({d1_resp_valid, d1_resp_id, d1_resp_data, d1_req_ready} !==
          {1'b1, 2'd1, 32'h3FC00000, 4'b0000}) begin
        bad++;
        $display("FAIL bp_hold%0d got=%b/%0d/%h/%b want=1/1/3fc00000/0000", c, d1_resp_valid,
                 d1_resp_id, d1_resp_data, d1_req_ready);
      end
    end
    d1_resp_ready = 1'b1;
    @(negedge clk);
    #1;
    total++;
    if ({d1_resp_valid, d1_req_ready} !== 5'b0_1000) begin
      bad++; $display("FAIL bp_release got=%b/%b want=0/1000", d1_resp_valid, d1_req_ready);
    end
    @(negedge clk);
    #1;
    total++;
    if ({d1_busy, d1_req_ready, d1_mul_a} !== {1'b1, 4'b0000, 32'h3F000000}) begin
      bad++;
      $display("FAIL bp_next_accept got=%b/%b/%h want=1/0000/3f000000", d1_busy, d1_req_ready,
               d1_mul_a);
    end
    d1_req_valid = '0;
    wait_resp(1'b0, 20, ok);
    total++;
    if (!ok || {d1_resp_id, d1_resp_data} !== {2'd3, 32'h3E800000}) begin
      bad++; $display("FAIL bp_next_resp got=%0d/%h want=3/3e800000", d1_resp_id, d1_resp_data);
    end
    @(negedge clk);
  endtask

  task automatic test_mul_lat3();
    bit ok;
    d3_req_a[0 +: 32] = 32'h40000000;
    d3_req_b[0 +: 32] = 32'h40400000;
    d3_resp_ready = 1'b1;
    d3_req_valid = 4'b0001;
    wait_ready(1'b1, 20, ok);
    total++;
    if (!ok || d3_req_ready !== 4'b0001) begin
      bad++; $display("FAIL lat3_grant got=%b want=0001", d3_req_ready);
    end
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      d3_req_valid = '0;
      #1;
      total++;
      if ({d3_resp_valid, d3_busy} !== 2'b01) begin
        bad++; $display("FAIL lat3_exec%0d got=%b%b want=01", k, d3_resp_valid, d3_busy);
      end
    end
    @(negedge clk);
    #1;
    total++;
    if ({d3_resp_valid, d3_busy, d3_resp_id, d3_resp_data} !== {4'b1100, 32'h40C00000}) begin
      bad++;
      $display("FAIL lat3_resp got=%b/%b/%0d/%h want=1/1/0/40c00000", d3_resp_valid, d3_busy,
               d3_resp_id, d3_resp_data);
    end
    @(negedge clk);
    #1;
    total++;
    if (d3_busy !== 1'b0) begin
      bad++; $display("FAIL lat3_idle got=%b want=0", d3_busy);
    end
  endtask

  task automatic test_reset_mid_exec();
    bit ok;
    bit seen;
    @(negedge clk);
    // Serve requester 2 first so ptr sits at 3 before the reset.
    d3_req_a[64 +: 32] = 32'hC0000000;
    d3_req_b[64 +: 32] = 32'h40800000;
    d3_req_a[96 +: 32] = 32'h3F000000;
    d3_req_b[96 +: 32] = 32'h3F000000;
    d3_req_a[32 +: 32] = 32'h3FC00000;
    d3_req_b[32 +: 32] = 32'h3FC00000;
    d3_resp_ready = 1'b1;
    d3_req_valid = 4'b0100;
    wait_ready(1'b1, 20, ok);
    @(negedge clk);
    d3_req_valid = '0;
    wait_resp(1'b1, 20, ok);
    total++;
    if (!ok || {d3_resp_id, d3_resp_data} !== {2'd2, 32'hC1000000}) begin
      bad++; $display("FAIL rst_pre_resp got=%0d/%h want=2/c1000000", d3_resp_id, d3_resp_data);
    end
    @(negedge clk);
    d3_req_valid = 4'b1000;
    wait_ready(1'b1, 20, ok);
    total++;
    if (!ok || d3_req_ready !== 4'b1000) begin
      bad++; $display("FAIL rst_pre_grant got=%b want=1000", d3_req_ready);
    end
    @(negedge clk);
    rst_n = 1'b0;
    d3_req_valid = '0;
    #1;
    total++;
    if ({d3_busy, d3_resp_valid} !== 2'b00) begin
      bad++; $display("FAIL rst_abort got=%b%b want=00", d3_busy, d3_resp_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      seen = seen | d3_resp_valid;
    end
    total++;
    if (seen !== 1'b0) begin
      bad++; $display("FAIL rst_no_resp got=%b want=0", seen);
    end
    d3_req_valid = 4'b1010;
    wait_ready(1'b1, 20, ok);
    total++;
    if (!ok || d3_req_ready !== 4'b0010) begin
      bad++; $display("FAIL rst_ptr_restart got=%b want=0010", d3_req_ready);
    end
    @(negedge clk);
    d3_req_valid = '0;
    wait_resp(1'b1, 20, ok);
    total++;
    if (!ok || {d3_resp_id, d3_resp_data} !== {2'd1, 32'h40100000}) begin
      bad++; $display("FAIL rst_post_resp got=%0d/%h want=1/40100000", d3_resp_id, d3_resp_data);
    end
    @(negedge clk);
  endtask

`ifdef FPMUL_ARB_FLAGS_EN
  task automatic test_flags();
    bit ok;
    @(negedge clk);
    d1_req_a[0 +: 32] = 32'h7F800000;
    d1_req_b[0 +: 32] = 32'h40000000;
    d1_resp_ready = 1'b1;
    d1_req_valid = 4'b0001;
    wait_ready(1'b0, 20, ok);
    @(negedge clk);
    d1_req_valid = '0;
    wait_resp(1'b0, 20, ok);
    total++;
    if (!ok || {d1_resp_data, d1_resp_flags} !== {32'h7F800000, 3'b010}) begin
      bad++; $display("FAIL flags_inf got=%h/%b want=7f800000/010", d1_resp_data, d1_resp_flags);
    end
    @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_round_robin();
    test_single();
    test_backpressure();
    test_mul_lat3();
    test_reset_mid_exec();
`ifdef FPMUL_ARB_FLAGS_EN
    test_flags();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
